slot_alloc96: RTL and testbench
===============================

SLOT_ALLOC96 -- requirements
Module: slot_alloc96

Interface
REQ-001 Parameter: NENT, 96, number of slots; fixed at 96 to match the flo96 encoder.
REQ-002 Parameter: IDXW, 7, index width; 7'd127 = "no slot".
REQ-003 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: alloc_req  input  1  request one free slot this cycle.
REQ-006 Port: alloc_ack  output  1  one-cycle pulse, alloc_idx valid.
REQ-007 Port: alloc_idx  output  7  granted slot index, held until next grant.
REQ-008 Port: alloc_fail  output  1  one-cycle pulse, request sampled with no free slot.
REQ-009 Port: free_req  input  1  return slot free_idx this cycle.
REQ-010 Port: free_idx  input  7  slot being returned.
REQ-011 Port: free_err  output  1  one-cycle pulse, illegal free (index>=96, or double free when checked).
REQ-012 Port: ready  output  1  block accepting requests.
REQ-013 Port: nfree  output  7  count of free slots, 0..96.
REQ-014 Port: empty / full  output  1 each  nfree==0 / nfree==96.

Function
REQ-015 Bitmap map[95:0] SHALL hold 1 = free; allocation always grants the lowest-index free slot.
REQ-016 FSM SHALL have states ST_INIT and ST_RUN; reset enters ST_INIT; ST_INIT lasts exactly one cycle, loads map to all ones and cand_q to 0, then goes to ST_RUN; ST_RUN is held until reset.
REQ-017 ready SHALL be 1 only in ST_RUN; requests while ready=0 are ignored without ack, fail or err.
REQ-018 Candidate register cand_q SHALL be loaded every cycle with flo96(map_d), where map_d is the next-state bitmap, so each grant uses no encoder in the request-to-ack path.
REQ-019 alloc_req sampled with ready=1 and cand_q!=127 SHALL produce alloc_ack=1 and alloc_idx=cand_q on the next cycle, clear map[cand_q], and decrement nfree; latency = 1 cycle.
REQ-020 Back-to-back requests SHALL be granted every cycle with distinct indices until empty.
REQ-021 alloc_req sampled with cand_q==127 SHALL give alloc_fail=1 next cycle; map and nfree unchanged.
REQ-022 Valid free_req SHALL set map[free_idx] and increment nfree on the next edge.
REQ-023 Simultaneous alloc and free in one cycle SHALL both take effect; nfree is unchanged; the freed slot is not granted in that same cycle and is eligible from the following request.
REQ-024 free_idx>=96 SHALL give free_err=1 next cycle with no state change.
REQ-025 nfree SHALL saturate logically: never below 0, never above 96.

Reset
REQ-026 Reset asserted at any time, including mid-grant, SHALL immediately force ST_INIT, alloc_ack=0, alloc_fail=0, free_err=0, alloc_idx=7'd127, nfree=0, ready=0, empty=1, full=0, map=0, cand_q=7'd127.
REQ-027 One cycle after deassertion (ST_INIT done), the outputs SHALL read nfree=96, full=1, empty=0, ready=1.

Configuration
REQ-028 Macro SLOT_ALLOC_DBLFREE_CHK_EN defined: freeing a slot already free SHALL pulse free_err and leave nfree unchanged.
REQ-029 Macro undefined: a double free SHALL be silently ignored; free_err is raised only for index>=96; no comparison logic is built.

Structure
REQ-030 Package slot_alloc_pkg SHALL hold NENT, IDXW, NO_SLOT=7'd127 and the state enum {ST_INIT, ST_RUN}.
REQ-031 Exactly one sub-module instance SHALL exist: flo96, driven by map_d. It returns the lowest set index, or 127 if none.

Verification
REQ-032 Reset release, then 96 consecutive alloc_req cycles -> acks with idx 0,1,...,95 on consecutive cycles; then full=0, empty=1, nfree=0.
REQ-033 With the map empty, alloc_req -> alloc_fail pulse, alloc_ack=0, nfree stays 0.
REQ-034 With the map empty: free 40, then free 7, then alloc, alloc -> grants 7 then 40; nfree 0->1->2->1->0.
REQ-035 With slot 5 allocated: same-cycle alloc_req plus free_req idx 5, with candidate 10 -> grant 10, nfree unchanged; the next alloc grants 5.
REQ-036 free_idx=100 -> free_err pulse; free of an already-free slot -> free_err only when SLOT_ALLOC_DBLFREE_CHK_EN is defined.
REQ-037 Assert rst_n low during an alloc stream -> outputs reach their reset values asynchronously; after release, ready is high on the second edge and the first grant is idx 0.

Source files
------------

// File: rtl/slot_alloc_pkg.sv
// rtl/slot_alloc_pkg.sv - shared constants, state enum and popcount helper for slot_alloc96
package slot_alloc_pkg;

   localparam int NENT = 96;
   localparam int IDXW = 7;
   localparam logic [IDXW-1:0] NO_SLOT = 7'd127;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic logic [IDXW-1:0] popcnt96(input logic [NENT-1:0] m);
      logic [IDXW-1:0] c;
      c = '0;
      for (int i = 0; i < NENT; i++) begin
         c = c + {{(IDXW-1){1'b0}}, m[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/slot_alloc96_flo96.sv
// rtl/slot_alloc96_flo96.sv - find-lowest-one encoder over the 96-slot bitmap
// Returns the lowest set index, or NO_SLOT when no bit is set.
module flo96
   import slot_alloc_pkg::*;
(
   input  logic [NENT-1:0] i_map,
   output logic [IDXW-1:0] o_idx
);

   always_comb begin
      o_idx = NO_SLOT;
      for (int i = NENT - 1; i >= 0; i--) begin
         if (i_map[i]) begin
            o_idx = IDXW'(i);
         end
      end
   end

endmodule

// File: rtl/slot_alloc96.sv
// rtl/slot_alloc96.sv - 96-entry lowest-index-first slot allocator with registered candidate
// Optional SLOT_ALLOC_DBLFREE_CHK_EN: report double frees on free_err.
module slot_alloc96
   import slot_alloc_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            alloc_req,
   output logic            alloc_ack,
   output logic [IDXW-1:0] alloc_idx,
   output logic            alloc_fail,
   input  logic            free_req,
   input  logic [IDXW-1:0] free_idx,
   output logic            free_err,
   output logic            ready,
   output logic [IDXW-1:0] nfree,
   output logic            empty,
   output logic            full
);

   state_t            r_state;
   state_t            w_state_nx;
   logic              w_ready;

   logic [NENT-1:0]   r_map;
   logic [NENT-1:0]   w_map_d;
   logic [IDXW-1:0]   r_cand;
   logic [IDXW-1:0]   w_cand_d;
   logic [IDXW-1:0]   r_nfree;
   logic [IDXW-1:0]   r_idx;
   logic              r_ack;
   logic              r_fail;
   logic              r_err;

   logic              w_grant;
   logic              w_fail;
   logic              w_idx_ok;
   logic              w_free_dbl;
   logic              w_free_set;
   logic              w_free_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_ready    = 1'b0;
      case (r_state)
         ST_INIT: w_state_nx = ST_RUN;
         ST_RUN:  w_ready    = 1'b1;
         default: w_state_nx = ST_INIT;
      endcase
   end

   // Grants come straight from the registered candidate; no encoder on this path.
   assign w_grant  = w_ready && alloc_req && (r_cand != NO_SLOT);
   assign w_fail   = w_ready && alloc_req && (r_cand == NO_SLOT);
   assign w_idx_ok = (free_idx < IDXW'(NENT));

`ifdef SLOT_ALLOC_DBLFREE_CHK_EN
   assign w_free_dbl = w_idx_ok && r_map[free_idx];
`else
   assign w_free_dbl = 1'b0;
`endif

   assign w_free_err = w_ready && free_req && (!w_idx_ok || w_free_dbl);
   assign w_free_set = w_ready && free_req && w_idx_ok && !w_free_dbl;

   // Set before clear so a granted slot always leaves the map, even on a same-index free.
   always_comb begin
      w_map_d = r_map;
      if (r_state == ST_INIT) begin
         w_map_d = '1;
      end else begin
         if (w_free_set) begin
            w_map_d[free_idx] = 1'b1;
         end
         if (w_grant) begin
            w_map_d[r_cand] = 1'b0;
         end
      end
   end

   flo96 u_flo96 (
      .i_map (w_map_d),
      .o_idx (w_cand_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_map   <= '0;
         r_cand  <= NO_SLOT;
         r_nfree <= '0;
         r_idx   <= NO_SLOT;
         r_ack   <= 1'b0;
         r_fail  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_map   <= w_map_d;
         r_cand  <= w_cand_d;
         r_nfree <= popcnt96(w_map_d);
         r_ack   <= w_grant;
         r_fail  <= w_fail;
         r_err   <= w_free_err;
         if (w_grant) begin
            r_idx <= r_cand;
         end
      end
   end

   assign alloc_ack  = r_ack;
   assign alloc_idx  = r_idx;
   assign alloc_fail = r_fail;
   assign free_err   = r_err;
   assign ready      = w_ready;
   assign nfree      = r_nfree;
   assign empty      = (r_nfree == '0);
   assign full       = (r_nfree == IDXW'(NENT));

endmodule

// File: tb/tb_slot_alloc96.sv
// tb/tb_slot_alloc96.sv - scoreboard bench for slot_alloc96
module tb_slot_alloc96;

   logic       clk;
   logic       rst_n;
   logic       alloc_req;
   logic       alloc_ack;
   logic [6:0] alloc_idx;
   logic       alloc_fail;
   logic       free_req;
   logic [6:0] free_idx;
   logic       free_err;
   logic       ready;
   logic [6:0] nfree;
   logic       empty;
   logic       full;

   slot_alloc96 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc_req  (alloc_req),
      .alloc_ack  (alloc_ack),
      .alloc_idx  (alloc_idx),
      .alloc_fail (alloc_fail),
      .free_req   (free_req),
      .free_idx   (free_idx),
      .free_err   (free_err),
      .ready      (ready),
      .nfree      (nfree),
      .empty      (empty),
      .full       (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ack;
      logic       fail;
      logic       err;
      logic [6:0] idx;
      int         nf;
   } exp_t;

   exp_t        sbq[$];
   logic [95:0] mmap;
   int          exp_nfree;
   logic [6:0]  exp_idx;
   int          n_pass;
   int          n_total;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int lowest();
      for (int i = 0; i < 96; i++) begin
         if (mmap[i]) return i;
      end
      return 127;
   endfunction

   task automatic model_init();
      mmap      = '1;
      exp_nfree = 96;
      exp_idx   = 7'd127;
      sbq.delete();
   endtask

   // One request cycle: push the expected outcome, clock, pop and compare.
   task automatic cyc(input logic a, input logic f, input logic [6:0] fi);
      exp_t e;
      int   lo;
      alloc_req = a;
      free_req  = f;
      free_idx  = fi;
      lo        = lowest();
      e.ack     = a && (lo != 127);
      e.fail    = a && (lo == 127);
`ifdef SLOT_ALLOC_DBLFREE_CHK_EN
      e.err     = f && ((fi >= 7'd96) || mmap[fi]);
`else
      e.err     = f && (fi >= 7'd96);
`endif
      if (f && (fi < 7'd96) && !mmap[fi]) begin
         mmap[fi] = 1'b1;
         exp_nfree++;
      end
      if (e.ack) begin
         mmap[lo] = 1'b0;
         exp_nfree--;
         exp_idx  = 7'(lo);
      end
      e.idx = exp_idx;
      e.nf  = exp_nfree;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      alloc_req = 1'b0;
      free_req  = 1'b0;
      free_idx  = 7'd0;
      e = sbq.pop_front();
      chk("alloc_ack", 32'(alloc_ack), 32'(e.ack));
      chk("alloc_fail", 32'(alloc_fail), 32'(e.fail));
      chk("free_err", 32'(free_err), 32'(e.err));
      chk("alloc_idx", 32'(alloc_idx), 32'(e.idx));
      chk("nfree", 32'(nfree), 32'(e.nf));
      chk("empty", 32'(empty), 32'(e.nf == 0));
      chk("full", 32'(full), 32'(e.nf == 96));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ack"}, 32'(alloc_ack), 32'd0);
      chk({tag, "_fail"}, 32'(alloc_fail), 32'd0);
      chk({tag, "_err"}, 32'(free_err), 32'd0);
      chk({tag, "_idx"}, 32'(alloc_idx), 32'd127);
      chk({tag, "_nfree"}, 32'(nfree), 32'd0);
      chk({tag, "_ready"}, 32'(ready), 32'd0);
      chk({tag, "_empty"}, 32'(empty), 32'd1);
      chk({tag, "_full"}, 32'(full), 32'd0);
   endtask

   // Release reset while a request is pending: the INIT cycle must ignore it.
   task automatic release_and_init(input string tag);
      rst_n     = 1'b1;
      alloc_req = 1'b1;
      free_req  = 1'b1;
      free_idx  = 7'd100;
      @(posedge clk);
      #1;
      alloc_req = 1'b0;
      free_req  = 1'b0;
      free_idx  = 7'd0;
      model_init();
      chk({tag, "_ready"}, 32'(ready), 32'd1);
      chk({tag, "_nfree"}, 32'(nfree), 32'd96);
      chk({tag, "_full"}, 32'(full), 32'd1);
      chk({tag, "_empty"}, 32'(empty), 32'd0);
      chk({tag, "_ack_ignored"}, 32'(alloc_ack), 32'd0);
      chk({tag, "_err_ignored"}, 32'(free_err), 32'd0);
   endtask

   initial begin
      n_pass    = 0;
      n_total   = 0;
      rst_n     = 1'b0;
      alloc_req = 1'b0;
      free_req  = 1'b0;
      free_idx  = 7'd0;
      mmap      = '0;
      exp_nfree = 0;
      exp_idx   = 7'd127;

      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      release_and_init("init");

      for (int i = 0; i < 96; i++) begin
         cyc(1'b1, 1'b0, 7'd0);
         chk("seq_idx", 32'(alloc_idx), 32'(i));
      end
      chk("drain_nfree", 32'(nfree), 32'd0);
      chk("drain_empty", 32'(empty), 32'd1);

      cyc(1'b1, 1'b0, 7'd0);
      chk("empty_fail", 32'(alloc_fail), 32'd1);

      cyc(1'b0, 1'b1, 7'd40);
      chk("f40_nfree", 32'(nfree), 32'd1);
      cyc(1'b0, 1'b1, 7'd7);
      chk("f7_nfree", 32'(nfree), 32'd2);
      cyc(1'b1, 1'b0, 7'd0);
      chk("grant7", 32'(alloc_idx), 32'd7);
      chk("g7_nfree", 32'(nfree), 32'd1);
      cyc(1'b1, 1'b0, 7'd0);
      chk("grant40", 32'(alloc_idx), 32'd40);
      chk("g40_nfree", 32'(nfree), 32'd0);

      cyc(1'b0, 1'b1, 7'd10);
      cyc(1'b1, 1'b1, 7'd5);
      chk("simul_grant10", 32'(alloc_idx), 32'd10);
      chk("simul_nfree", 32'(nfree), 32'd1);
      cyc(1'b1, 1'b0, 7'd0);
      chk("after_simul_grant5", 32'(alloc_idx), 32'd5);

      cyc(1'b0, 1'b1, 7'd100);
      chk("range_err", 32'(free_err), 32'd1);
      cyc(1'b0, 1'b1, 7'd127);
      cyc(1'b0, 1'b1, 7'd95);
      cyc(1'b0, 1'b1, 7'd95);
      chk("dbl_nfree", 32'(nfree), 32'd1);
      cyc(1'b0, 1'b1, 7'd20);
      cyc(1'b1, 1'b1, 7'd3);
      cyc(1'b1, 1'b0, 7'd0);
      cyc(1'b1, 1'b0, 7'd0);
      cyc(1'b1, 1'b0, 7'd0);

      cyc(1'b0, 1'b1, 7'd60);
      cyc(1'b0, 1'b1, 7'd61);
      alloc_req = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      @(posedge clk);
      #1;
      chk_reset_vals("held_rst");
      release_and_init("reinit");
      cyc(1'b1, 1'b0, 7'd0);
      chk("first_grant", 32'(alloc_idx), 32'd0);
      cyc(1'b1, 1'b0, 7'd0);
      chk("second_grant", 32'(alloc_idx), 32'd1);
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
